// File: rtl/xfer_status_pkg.sv
// rtl/xfer_status_pkg.sv - shared types and helpers for the transfer status tracker
package xfer_status_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY  = 2'b01,
    ST_DRAIN = 2'b10,
    ST_DONE  = 2'b11
  } xfer_state_e;

  localparam int DRAIN_MAX_DEF = 8;

  function automatic int drain_cnt_w(input int drain_max);
    return $clog2(drain_max + 1);
  endfunction

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/xfer_status_ch.sv
// rtl/xfer_status_ch.sv - one channel's completion FSM, drain window counter and sticky error
module xfer_status_ch
  import xfer_status_pkg::*;
#(
  parameter int DRAIN_MAX = DRAIN_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_read,
  input  logic i_write,
  input  logic i_done,
  input  logic i_ack,
  output logic o_idle,
  output logic o_done,
  output logic o_err,
  output logic o_enter_done
);

  localparam int DCW = drain_cnt_w(DRAIN_MAX);
  localparam logic [DCW-1:0] LP_LAST = DCW'(DRAIN_MAX - 1);

  xfer_state_e    r_state;
  logic [DCW-1:0] r_cnt;
  logic           r_err;

  xfer_state_e    w_next;
  logic [DCW-1:0] w_cnt_next;
  logic           w_err_next;
  logic           w_strobe;

  assign w_strobe = i_read | i_write;

  // Ack clears err in every state; a timeout in the same cycle re-sets it.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_err_next = r_err & ~i_ack;
    case (r_state)
      ST_IDLE: begin
        if (i_done)        w_next = ST_DONE;
        else if (w_strobe) w_next = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_done) begin
          if (w_strobe) begin
            w_next     = ST_DRAIN;
            w_cnt_next = '0;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_DRAIN: begin
        if (!w_strobe) begin
          w_next = ST_DONE;
        end else if (r_cnt == LP_LAST) begin
          w_next     = ST_DONE;
          w_err_next = 1'b1;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_DONE: begin
        if (w_strobe)   w_next = ST_BUSY;
        else if (i_ack) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  assign o_idle       = (r_state == ST_IDLE);
  assign o_done       = (r_state == ST_DONE);
  assign o_err        = r_err;
  assign o_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);

endmodule

// File: rtl/xfer_status_tracker.sv
// rtl/xfer_status_tracker.sv - multi-channel transfer completion tracker with irq and completion counter
module xfer_status_tracker
  import xfer_status_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DRAIN_MAX = DRAIN_MAX_DEF,
  parameter int CNT_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] read_i,
  input  logic [NUM_CH-1:0] write_i,
  input  logic [NUM_CH-1:0] done_i,
  input  logic [NUM_CH-1:0] ack_i,
  input  logic [NUM_CH-1:0] irq_en_i,
  input  logic              cnt_clr_i,
  output logic [NUM_CH-1:0] idle_o,
  output logic [NUM_CH-1:0] done_o,
  output logic [NUM_CH-1:0] err_o,
  output logic              all_idle_o,
  output logic              irq_o,
  output logic [CNT_W-1:0]  cmpl_cnt_o
);

  localparam int SW = CNT_W + 5;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NUM_CH-1:0] w_enter_done;
  logic [15:0]       w_enter16;
  logic [SW-1:0]     w_sum;
  logic [CNT_W-1:0]  w_cnt_next;
  logic [CNT_W-1:0]  r_cnt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    xfer_status_ch #(
      .DRAIN_MAX(DRAIN_MAX)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_read      (read_i[g]),
      .i_write     (write_i[g]),
      .i_done      (done_i[g]),
      .i_ack       (ack_i[g]),
      .o_idle      (idle_o[g]),
      .o_done      (done_o[g]),
      .o_err       (err_o[g]),
      .o_enter_done(w_enter_done[g])
    );
  end

  assign w_enter16  = 16'(w_enter_done);
  assign w_sum      = SW'(r_cnt) + SW'(popcount16(w_enter16));
  assign w_cnt_next = (w_sum > SW'(CNT_MAX)) ? CNT_MAX : w_sum[CNT_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_cnt <= '0;
    else if (cnt_clr_i) r_cnt <= '0;
    else                r_cnt <= w_cnt_next;
  end

  assign cmpl_cnt_o = r_cnt;
  assign all_idle_o = &idle_o;
  assign irq_o      = |(done_o & irq_en_i);

endmodule

// File: tb/tb_xfer_status_tracker.sv
// tb/tb_xfer_status_tracker.sv - directed table-driven bench for xfer_status_tracker
module tb_xfer_status_tracker;

  logic       clk;
  logic       rst_n;
  logic [3:0] read_i, write_i, done_i, ack_i, irq_en_i;
  logic       cnt_clr_i;

  logic [3:0] idle_o, done_o, err_o;
  logic       all_idle_o, irq_o;
  logic [7:0] cmpl_cnt_o;

  logic [3:0] s_idle, s_done, s_err;
  logic       s_all_idle, s_irq;
  logic [1:0] s_cnt;

  int n_chk;
  int n_fail;

  xfer_status_tracker #(.NUM_CH(4), .DRAIN_MAX(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_i(write_i), .done_i(done_i),
    .ack_i(ack_i), .irq_en_i(irq_en_i), .cnt_clr_i(cnt_clr_i),
    .idle_o(idle_o), .done_o(done_o), .err_o(err_o), .all_idle_o(all_idle_o),
    .irq_o(irq_o), .cmpl_cnt_o(cmpl_cnt_o)
  );

  xfer_status_tracker #(.NUM_CH(4), .DRAIN_MAX(8), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .read_i(read_i), .write_i(write_i), .done_i(done_i),
    .ack_i(ack_i), .irq_en_i(irq_en_i), .cnt_clr_i(cnt_clr_i),
    .idle_o(s_idle), .done_o(s_done), .err_o(s_err), .all_idle_o(s_all_idle),
    .irq_o(s_irq), .cmpl_cnt_o(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] rd, wr, dn, ack, en;
    logic       clr;
    logic [3:0] idle, done;
    logic [7:0] cnt;
    logic [1:0] cnt_s;
    logic       irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] rd, wr, dn, ack, en, input logic clr,
                     input logic [3:0] idle, done, input logic [7:0] cnt,
                     input logic [1:0] cnt_s, input logic irq);
    vec_t v;
    v.rd = rd; v.wr = wr; v.dn = dn; v.ack = ack; v.en = en; v.clr = clr;
    v.idle = idle; v.done = done; v.cnt = cnt; v.cnt_s = cnt_s; v.irq = irq;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] rd, wr, dn, ack, en, input logic clr);
    @(negedge clk);
    read_i = rd; write_i = wr; done_i = dn; ack_i = ack; irq_en_i = en; cnt_clr_i = clr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 1'b0;
    read_i = '0; write_i = '0; done_i = '0; ack_i = '0; irq_en_i = '0; cnt_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // reset / idle state
    step(0, 0, 0, 0, 0, 0);
    chk("rst_idle", 32'(idle_o), 32'hF);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_all_idle", 32'(all_idle_o), 32'h1);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_cnt", 32'(cmpl_cnt_o), 32'h0);

    // ch0: read 5, write 5 with done on the last, write one more, then drop
    for (int i = 0; i < 5; i++) add(4'h1, 0, 0, 0, 4'h1, 0, 4'hE, 4'h0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'h1, 0, 0, 4'h1, 0, 4'hE, 4'h0, 0, 0, 0);
    add(0, 4'h1, 4'h1, 0, 4'h1, 0, 4'hE, 4'h0, 0, 0, 0);
    add(0, 4'h1, 0,    0, 4'h1, 0, 4'hE, 4'h0, 0, 0, 0);
    add(0, 0,    0,    0, 4'h1, 0, 4'hE, 4'h1, 1, 1, 1);
    add(0, 0,    0,    0, 4'h0, 0, 4'hE, 4'h1, 1, 1, 0);
    add(0, 0,    0, 4'h1, 4'h1, 0, 4'hF, 4'h0, 1, 1, 0);
    // ch2 zero-length done, then ack + read in the same cycle
    add(0,    0, 4'h4, 0,    4'h4, 0, 4'hB, 4'h4, 2, 2, 1);
    add(4'h4, 0, 0,    4'h4, 4'h4, 0, 4'hB, 4'h0, 2, 2, 0);
    // ch0/2/3 complete together; narrow counter saturates
    add(4'hD, 0, 0,    0,    0,    0, 4'h2, 4'h0, 2, 2, 0);
    add(0,    0, 4'hD, 0,    4'hF, 0, 4'h2, 4'hD, 5, 3, 1);
    add(0,    0, 0,    0,    4'h2, 0, 4'h2, 4'hD, 5, 3, 0);
    add(0,    0, 0,    4'hD, 0,    0, 4'hF, 4'h0, 5, 3, 0);
    // clear wins over same-cycle completions
    add(4'hD, 0, 0,    0,    0,    0, 4'h2, 4'h0, 5, 3, 0);
    add(0,    0, 4'hD, 0,    0,    1, 4'h2, 4'hD, 0, 0, 0);
    add(0,    0, 0,    0,    0,    0, 4'h2, 4'hD, 0, 0, 0);
    add(0,    0, 0,    4'hD, 0,    0, 4'hF, 4'h0, 0, 0, 0);
    // ack in BUSY leaves state alone
    add(4'h1, 0, 0,    0,    0,    0, 4'hE, 4'h0, 0, 0, 0);
    add(0,    0, 0,    4'h1, 0,    0, 4'hE, 4'h0, 0, 0, 0);
    add(0,    0, 4'h1, 0,    0,    0, 4'hE, 4'h1, 1, 1, 0);
    add(0,    0, 0,    4'h1, 0,    0, 4'hF, 4'h0, 1, 1, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].dn, vecs[i].ack, vecs[i].en, vecs[i].clr);
      chk($sformatf("v%0d_idle", i), 32'(idle_o), 32'(vecs[i].idle));
      chk($sformatf("v%0d_done", i), 32'(done_o), 32'(vecs[i].done));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'h0);
      chk($sformatf("v%0d_all_idle", i), 32'(all_idle_o), 32'(vecs[i].idle == 4'hF));
      chk($sformatf("v%0d_irq", i), 32'(irq_o), 32'(vecs[i].irq));
      chk($sformatf("v%0d_cnt", i), 32'(cmpl_cnt_o), 32'(vecs[i].cnt));
      chk($sformatf("v%0d_s_cnt", i), 32'(s_cnt), 32'(vecs[i].cnt_s));
      chk($sformatf("v%0d_s_idle", i), 32'(s_idle), 32'(vecs[i].idle));
      chk($sformatf("v%0d_s_done", i), 32'(s_done), 32'(vecs[i].done));
      chk($sformatf("v%0d_s_err", i), 32'(s_err), 32'h0);
      chk($sformatf("v%0d_s_all_idle", i), 32'(s_all_idle), 32'(vecs[i].idle == 4'hF));
      chk($sformatf("v%0d_s_irq", i), 32'(s_irq), 32'(vecs[i].irq));
    end

    // ch1 drain timeout: DONE exactly 8 edges after entering DRAIN
    step(0, 4'h2, 0, 0, 0, 0);
    step(0, 4'h2, 4'h2, 0, 0, 0);
    chk("to_enter_done", 32'(done_o), 32'h0);
    chk("to_enter_idle", 32'(idle_o), 32'hD);
    for (int k = 1; k <= 8; k++) begin
      step(0, 4'h2, 0, 0, 0, 0);
      chk($sformatf("to_k%0d_done", k), 32'(done_o[1]), 32'(k == 8));
      chk($sformatf("to_k%0d_err", k), 32'(err_o[1]), 32'(k == 8));
    end
    chk("to_cnt", 32'(cmpl_cnt_o), 32'd2);
    step(0, 4'h2, 0, 0, 0, 0);
    chk("to_restart_done", 32'(done_o), 32'h0);
    chk("to_restart_idle", 32'(idle_o), 32'hD);
    chk("to_restart_err", 32'(err_o), 32'h2);
    step(0, 0, 0, 0, 0, 0);
    chk("to_hold_err", 32'(err_o), 32'h2);
    step(0, 0, 0, 4'h2, 0, 0);
    chk("to_ack_err", 32'(err_o), 32'h0);
    chk("to_ack_idle", 32'(idle_o), 32'hD);
    step(0, 0, 4'h2, 0, 0, 0);
    chk("to_done2", 32'(done_o), 32'h2);
    chk("to_cnt2", 32'(cmpl_cnt_o), 32'd3);
    step(0, 0, 0, 4'h2, 0, 0);
    chk("to_final_idle", 32'(idle_o), 32'hF);

    // async reset while ch3 is in DRAIN
    step(4'h8, 0, 0, 0, 0, 0);
    step(4'h8, 0, 4'h8, 0, 0, 0);
    step(4'h8, 0, 0, 0, 0, 0);
    chk("ar_pre_idle", 32'(idle_o), 32'h7);
    chk("ar_pre_done", 32'(done_o), 32'h0);
    @(negedge clk);
    read_i = '0; write_i = '0; done_i = '0; ack_i = '0; irq_en_i = '0; cnt_clr_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_idle", 32'(idle_o), 32'hF);
    chk("ar_done", 32'(done_o), 32'h0);
    chk("ar_err", 32'(err_o), 32'h0);
    chk("ar_cnt", 32'(cmpl_cnt_o), 32'h0);
    chk("ar_all_idle", 32'(all_idle_o), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    chk("ar_post_idle", 32'(idle_o), 32'hF);
    chk("ar_post_cnt", 32'(cmpl_cnt_o), 32'h0);
    chk("ar_post_s_cnt", 32'(s_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/xfer_status_tracker.md
Name: xfer_status_tracker

Overview:
Multi-channel completion/status tracker for the bus-adapter transfer path. Each channel observes its read/write strobes and the counter FSM done pulse, and drives registered idle/done status. The block replaces glitch-prone, delay-based status gating with a per-channel FSM. It adds a bounded write-drain window, a sticky timeout error, software acknowledge, an interrupt line and a completion counter. It sits between the per-channel counter FSMs/bus adapters and the top-level status/interrupt logic.

Parameters:
NUM_CH, 4, number of independent transfer channels (1..16)
DRAIN_MAX, 8, maximum cycles allowed in DRAIN for read/write strobes to fall after done (>=1)
CNT_W, 8, width of the saturating completion counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
read_i  input  NUM_CH  per-channel read strobe from bus adapter
write_i  input  NUM_CH  per-channel write strobe from bus adapter
done_i  input  NUM_CH  per-channel done pulse from counter FSM
ack_i  input  NUM_CH  per-channel software acknowledge; clears DONE and err
irq_en_i  input  NUM_CH  per-channel interrupt enable
cnt_clr_i  input  1  synchronous clear of completion counter
idle_o  output  NUM_CH  channel in IDLE
done_o  output  NUM_CH  channel in DONE
err_o  output  NUM_CH  sticky drain-timeout error
all_idle_o  output  1  AND of idle_o
irq_o  output  1  OR of (done_o & irq_en_i)
cmpl_cnt_o  output  CNT_W  saturating count of DONE entries

Behaviour:
- Reset (async, rst_n=0): every channel is IDLE, drain counter 0, err 0, cmpl_cnt 0. Resulting outputs: idle_o all 1, done_o 0, err_o 0, all_idle_o 1, irq_o 0.
- idle_o and done_o decode directly from state flops. They carry no combinational dependency on inputs and have no # delays.
- Per-channel FSM, states IDLE, BUSY, DRAIN, DONE:
  - IDLE: done_i -> DONE (zero-length transfer). Otherwise read_i|write_i -> BUSY.
  - BUSY: done_i and (read_i|write_i) -> DRAIN with drain cnt=0. done_i alone -> DONE. Otherwise stay.
  - DRAIN: read_i|write_i both 0 -> DONE. Otherwise cnt++. If cnt==DRAIN_MAX-1 while a strobe is still high -> DONE and set err. DRAIN therefore lasts at most DRAIN_MAX cycles. done_i is ignored.
  - DONE: read_i|write_i -> BUSY (restart); err is kept unless ack_i is also set. ack_i without strobes -> IDLE. done_i is ignored.
- Same-cycle ack_i and restart in DONE: go to BUSY, and ack still clears err.
- ack_i in IDLE, BUSY or DRAIN clears err only; it has no effect on state.
- err is set only by drain timeout and is cleared only by ack_i or reset.
- Latency: done_o rises exactly 1 clock after the qualifying input edge. With done_i and strobes falling in the same cycle, done_o=1 on the next edge.
- Completion counter:
  - Each cycle, add the number of channels transitioning into DONE, computed as a popcount of next-state DONE and not current-state DONE.
  - Saturate at 2^CNT_W-1.
  - cnt_clr_i has priority: the counter becomes 0 that cycle and that cycle's increments are dropped.
- all_idle_o and irq_o are combinational reductions of registered state and inputs. irq_o is a level and follows done_o/irq_en_i.
- Reset mid-operation (any state, including DRAIN): immediately return to IDLE. The counter and err are lost.
- The block does not synchronise its inputs; they must be in the clk domain.

Decomposition:
- Shared package xfer_status_pkg holds:
  - the state enum: IDLE=2'b00, BUSY=2'b01, DRAIN=2'b10, DONE=2'b11
  - a localparam drain-counter width of $clog2(DRAIN_MAX+1)
  - a popcount function
- Sub-module xfer_status_ch: one channel's FSM, drain counter and err flop, exporting state, idle, done, err and an enter_done pulse.
- The top instantiates NUM_CH copies via generate, then adds the reductions and the counter.

Test Plan:
1. Reset, then idle: all inputs 0 -> idle_o=4'hF, done_o=0, err_o=0, all_idle_o=1, cmpl_cnt_o=0.
2. Channel 0 read 5 cycles, then write 5 cycles, with done_i pulsed on the last write cycle while write_i stays high 1 more cycle:
   - BUSY -> DRAIN -> DONE.
   - done_o[0]=1 two edges after done_i, err_o[0]=0, cmpl_cnt_o=1.
   - irq_o=1 with irq_en_i[0]=1; ack_i[0] -> idle_o[0]=1 next edge.
3. Drain timeout on channel 1: done_i with write_i held high for 20 cycles -> done_o[1]=1 exactly 8 edges after entering DRAIN, err_o[1]=1. Error stays set through a restart; ack_i[1] -> err_o[1]=0.
4. Channels 0, 2 and 3 hit done_i in the same cycle from BUSY -> cmpl_cnt_o increments by 3 in one edge. With CNT_W=2 and preload to 2, the counter saturates at 3. cnt_clr_i in the same cycle -> 0.
5. Channel 2 in DONE, ack_i[2] and read_i[2] in the same cycle -> state BUSY, done_o[2]=0, idle_o[2]=0, cmpl_cnt unchanged.
6. Assert rst_n low asynchronously while channel 3 is in DRAIN (mid-clock) -> idle_o[3]=1, done_o[3]=0 and err_o[3]=0 before the next edge. No DONE entry is counted after release.
